halfbridge_monitor: RTL
=======================

Name: halfbridge_monitor

Overview:
- Receive-side checker for the half-bridge gate pair produced by the PWM/dead-time generator.
- Samples the two gate signals (s, nots) on the system clock and decodes them back into per-period on-time and period counts.
- Measures both dead-time gaps and flags dead-time violations, shoot-through and stalled switching.
- Sits beside the generator for closed-loop self-test; can also monitor the gate pins.

Parameters:
CNT_W, 16, width of the on-time, period and dead-time counters (clk cycles)
MIN_DT, 50, minimum legal dead-time in clk cycles (500 ns at 100 MHz)
TIMEOUT, 60000, period-counter value at which switching is declared stalled (must be < 2^CNT_W)

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
s_in  in  1  high-side gate signal, asynchronous to clk
nots_in  in  1  low-side gate signal, asynchronous to clk
clr  in  1  synchronous clear of sticky flags and dt_min
on_time  out  CNT_W  s-high samples in last completed period
period  out  CNT_W  samples in last completed period, rising edge to rising edge
meas_valid  out  1  one-cycle pulse when on_time/period update
dt_lead  out  CNT_W  last gap, s falling to nots rising
dt_trail  out  CNT_W  last gap, nots falling to s rising
dt_min  out  CNT_W  smallest gap seen since reset/clr
dt_err  out  1  sticky: some gap < MIN_DT
shoot_through  out  1  sticky: s and nots sampled high together
stall  out  1  no s rising edge for TIMEOUT samples

Behaviour:
- Reset (rst_n low, async): all outputs 0 except dt_min = all ones. Synchronizers are cleared, state = IDLE.
- Input path: each of s_in and nots_in passes through a 2-FF synchronizer and then a 1-FF history register used for edge detection. Synchronized sample = ss, sn.
- Latency: an input edge is detected 3 clk after it occurs.
- States:
  - IDLE: wait for ss rising. On ss rising go to HIGH, with per_cnt = 1 and on_cnt = 1.
  - HIGH: per_cnt+1 and on_cnt+1 per sample while ss = 1. On ss falling go to LOW.
  - LOW: per_cnt+1 per sample. On ss rising:
    - period <= per_cnt, on_time <= on_cnt; meas_valid pulses for 1 cycle.
    - Restart with per_cnt = 1, on_cnt = 1, go to HIGH.
- The first rising edge after reset, clr or stall produces no meas_valid; a full period is required.
- Dead-time measurement:
  - gap counter counts samples with ss = 0 and sn = 0.
  - It starts at the ss falling edge (lead) or the sn falling edge (trail).
  - It ends at the next sn rising edge (lead) or ss rising edge (trail). The final count goes to dt_lead or dt_trail.
  - At each gap end: dt_min <= min(dt_min, gap); dt_err set if gap < MIN_DT. A gap of 0 (simultaneous toggle) counts as a violation.
  - A gap is not measured when the opposite gate never rose, e.g. s re-rises without nots pulsing (duty-100 operation).
- shoot_through: set on any sample with ss = 1 and sn = 1. Sticky.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Stall:
  - If per_cnt reaches TIMEOUT in HIGH or LOW, or IDLE lasts TIMEOUT samples, set stall and go to IDLE. meas_valid is not asserted.
  - stall clears on the next ss rising edge.
- clr, 1 cycle:
  - Clears dt_err, shoot_through and stall; dt_min = all ones; state goes to IDLE. on_time, period, dt_lead and dt_trail hold.
  - If clr coincides with a flag-setting event, clr wins that cycle.
- rst_n asserted mid-period: immediate return to the reset values; no partial measurement is reported.

Test Plan:
- Steady PWM: s high 300, low 700 clk, nots complementary with 60-clk gaps → after the 2nd rising edge, meas_valid once per 1000 clk with period = 1000, on_time = 300, dt_lead = dt_trail = 60, dt_err = 0.
- Short dead-time: gap 40 clk with MIN_DT = 50 → dt_err = 1 after the first gap, dt_min = 40. clr → dt_err = 0, dt_min = 0xFFFF.
- Overlap: nots rises 5 clk before s falls → shoot_through = 1 within 3 clk and stays set until clr.
- Stall: s held low for 60000+ clk after running → stall = 1, no meas_valid. Resume PWM → stall = 0 at the first rising edge, meas_valid after one full period.
- Duty change: on-time 300 → 900 mid-run → the next completed period reports on_time = 900, period = 1000.
- Async reset mid-HIGH: rst_n low for 3 clk → all outputs return to reset values; the first meas_valid after release occurs only after two rising edges.

Source files
------------

// File: rtl/halfbridge_monitor.sv
// Purpose : decodes a half-bridge gate pair (s, nots) into on-time/period and dead-time gaps;
//           raises sticky dead-time, shoot-through and stall flags.
// Latency : an input edge is acted on 3 clk after it occurs (2-FF sync + 1-FF history);
//           measurements update on the registered cycle after the detected edge.
// Backpressure: none; this is a free-running observer, and meas_valid is a single-cycle pulse with no ready signal.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   s_in, nots_in       raw gate signals (asynchronous to clk)
//   clr                 one-cycle clear of sticky flags and dt_min; restarts measurement from IDLE
//   on_time, period     last completed period (rising to rising edge of s), in clk samples
//   meas_valid          pulses when on_time/period update
//   dt_lead, dt_trail   last s-fall->nots-rise and nots-fall->s-rise gaps
//   dt_min              smallest gap since reset/clr (all ones until a gap is measured)
//   dt_err              sticky: a gap shorter than MIN_DT
//   shoot_through       sticky: both gates sampled high together
//   stall               no s rising edge for TIMEOUT samples; clears on the next rising edge
module halfbridge_monitor #(
    parameter int CNT_W   = 16,
    parameter int MIN_DT  = 50,
    parameter int TIMEOUT = 60000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_in,
    input  logic             nots_in,
    input  logic             clr,
    output logic [CNT_W-1:0] on_time,
    output logic [CNT_W-1:0] period,
    output logic             meas_valid,
    output logic [CNT_W-1:0] dt_lead,
    output logic [CNT_W-1:0] dt_trail,
    output logic [CNT_W-1:0] dt_min,
    output logic             dt_err,
    output logic             shoot_through,
    output logic             stall
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_VAL = CNT_W'(MIN_DT);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    typedef enum logic [1:0] {GAP_NONE, GAP_LEAD, GAP_TRAIL} gap_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Input synchronizers plus one history stage for edge detection
    // ------------------------------------------------------------------
    logic s_meta, ss, s_hist;
    logic n_meta, sn, n_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta <= 1'b0;
            ss     <= 1'b0;
            s_hist <= 1'b0;
            n_meta <= 1'b0;
            sn     <= 1'b0;
            n_hist <= 1'b0;
        end else begin
            s_meta <= s_in;
            ss     <= s_meta;
            s_hist <= ss;
            n_meta <= nots_in;
            sn     <= n_meta;
            n_hist <= sn;
        end
    end

    logic s_rise, s_fall, n_rise, n_fall;
    assign s_rise = ss & ~s_hist;
    assign s_fall = ~ss & s_hist;
    assign n_rise = sn & ~n_hist;
    assign n_fall = ~sn & n_hist;

    // ------------------------------------------------------------------
    // Period / on-time FSM. per_cnt doubles as the idle-timeout counter
    // while in IDLE.
    // ------------------------------------------------------------------
    state_t           state, state_nxt;
    logic [CNT_W-1:0] per_cnt, per_nxt;
    logic [CNT_W-1:0] on_cnt, on_nxt;
    logic             meas_nxt;
    logic             stall_set, stall_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            per_cnt <= '0;
            on_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            per_cnt <= per_nxt;
            on_cnt  <= on_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        per_nxt     = per_cnt;
        on_nxt      = on_cnt;
        meas_nxt    = 1'b0;
        stall_set   = 1'b0;
        stall_clear = 1'b0;
        case (state)
            IDLE: begin
                if (s_rise) begin
                    // First edge only arms the measurement; no period yet.
                    state_nxt   = HIGH;
                    per_nxt     = CNT_W'(1);
                    on_nxt      = CNT_W'(1);
                    stall_clear = 1'b1;
                end else if (per_cnt == TO_VAL) begin
                    stall_set = 1'b1;
                    per_nxt   = '0;
                end else begin
                    per_nxt = sat_inc(per_cnt);
                end
            end
            HIGH: begin
                if (per_cnt == TO_VAL) begin
                    stall_set = 1'b1;
                    state_nxt = IDLE;
                    per_nxt   = '0;
                end else if (s_fall) begin
                    per_nxt   = sat_inc(per_cnt);
                    state_nxt = LOW;
                end else begin
                    per_nxt = sat_inc(per_cnt);
                    on_nxt  = sat_inc(on_cnt);
                end
            end
            LOW: begin
                if (per_cnt == TO_VAL) begin
                    stall_set = 1'b1;
                    state_nxt = IDLE;
                    per_nxt   = '0;
                end else if (s_rise) begin
                    meas_nxt  = 1'b1;
                    state_nxt = HIGH;
                    per_nxt   = CNT_W'(1);
                    on_nxt    = CNT_W'(1);
                end else begin
                    per_nxt = sat_inc(per_cnt);
                end
            end
            default: begin
                state_nxt = IDLE;
                per_nxt   = '0;
            end
        endcase
        // clr restarts from IDLE and overrides anything this cycle.
        if (clr) begin
            state_nxt   = IDLE;
            per_nxt     = '0;
            on_nxt      = '0;
            meas_nxt    = 1'b0;
            stall_set   = 1'b0;
            stall_clear = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_valid <= 1'b0;
            period     <= '0;
            on_time    <= '0;
            stall      <= 1'b0;
        end else begin
            meas_valid <= meas_nxt;
            if (meas_nxt) begin
                period  <= per_cnt;
                on_time <= on_cnt;
            end
            if (clr)
                stall <= 1'b0;
            else if (stall_set)
                stall <= 1'b1;
            else if (stall_clear)
                stall <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Dead-time gap measurement. A gap opens on a falling edge and closes
    // on the opposite gate's rising edge; any rising edge that does not
    // close the open gap abandons it (e.g. s re-rising at 100% duty).
    // ------------------------------------------------------------------
    gap_t             gap_mode, gap_eff;
    logic [CNT_W-1:0] gap_cnt, gap_base, gap_acc;
    logic             lead_end, trail_end, gap_end;

    always_comb begin
        gap_eff = gap_mode;
        if (s_fall)
            gap_eff = GAP_LEAD;
        else if (n_fall)
            gap_eff = GAP_TRAIL;
        gap_base  = (s_fall | n_fall) ? '0 : gap_cnt;
        gap_acc   = (~ss & ~sn) ? sat_inc(gap_base) : gap_base;
        // Both-edges-in-one-sample closes with a zero-length gap.
        lead_end  = (gap_eff == GAP_LEAD) & n_rise;
        trail_end = (gap_eff == GAP_TRAIL) & s_rise;
        gap_end   = lead_end | trail_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_mode      <= GAP_NONE;
            gap_cnt       <= '0;
            dt_lead       <= '0;
            dt_trail      <= '0;
            dt_min        <= '1;
            dt_err        <= 1'b0;
            shoot_through <= 1'b0;
        end else if (clr) begin
            // A gap spanning a clear would mix old and new history; drop it.
            gap_mode      <= GAP_NONE;
            gap_cnt       <= '0;
            dt_min        <= '1;
            dt_err        <= 1'b0;
            shoot_through <= 1'b0;
        end else begin
            gap_mode <= (s_rise | n_rise) ? GAP_NONE : gap_eff;
            gap_cnt  <= gap_acc;
            if (lead_end)
                dt_lead <= gap_acc;
            if (trail_end)
                dt_trail <= gap_acc;
            if (gap_end && (gap_acc < dt_min))
                dt_min <= gap_acc;
            if (gap_end && (gap_acc < MIN_VAL))
                dt_err <= 1'b1;
            if (ss && sn)
                shoot_through <= 1'b1;
        end
    end

endmodule
